// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/execute control unit driving every register-transfer strobe of the single-bus datapath.
// Optional macro SINGLE_STEP_EN adds a step input and a STEP_WAIT pause after each instruction.
module ctrl_sequencer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int NUM_REGS     = 16
) (
  input  logic                clk_i,
  input  logic                clear_ni,
  input  logic                start_i,
  input  logic                mem_ready_i,
  input  logic [31:0]         ir_i,
`ifdef SINGLE_STEP_EN
  input  logic                step_i,
`endif
  output logic                pcout_o,
  output logic                zhighout_o,
  output logic                zlowout_o,
  output logic                mdrout_o,
  output logic                marin_o,
  output logic                pcin_o,
  output logic                mdrin_o,
  output logic                irin_o,
  output logic                yin_o,
  output logic                zin_o,
  output logic                hiin_o,
  output logic                loin_o,
  output logic                incpc_o,
  output logic                read_o,
  output logic [NUM_REGS-1:0] rout_o,
  output logic [NUM_REGS-1:0] rin_o,
  output logic [4:0]          alu_op_o,
  output logic                run_o,
  output logic                instr_done_o,
  output logic                illegal_o,
  output logic                bus_err_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
`ifdef SINGLE_STEP_EN
    , S_STEP
`endif
  } state_e;

  localparam logic [4:0] OP_MUL  = 5'b01100;
  localparam logic [4:0] OP_DIV  = 5'b01101;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

`ifdef SINGLE_STEP_EN
  localparam state_e S_NEXT = S_STEP;
`else
  localparam state_e S_NEXT = S_T0;
`endif

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_md;
  logic       unused_ir_bits;

  assign op     = ir_i[31:27];
  assign ra     = ir_i[26:23];
  assign rb     = ir_i[22:19];
  assign rc     = ir_i[18:15];
  assign is_alu = (op <= 5'b01011);
  assign is_md  = (op == OP_MUL) || (op == OP_DIV);
  assign unused_ir_bits = ^ir_i[14:0];

  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [3:0] idx);
    reg_sel = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

`ifdef SINGLE_STEP_EN
  logic step_q, step_prev_q, step_rise;
  assign step_rise = step_q & ~step_prev_q;
`endif

  always_ff @(posedge clk_i or negedge clear_ni) begin
    if (!clear_ni) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
`ifdef SINGLE_STEP_EN
      step_q      <= 1'b0;
      step_prev_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
`ifdef SINGLE_STEP_EN
      step_q      <= step_i;
      step_prev_q <= step_q;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_T0;
      S_T0: begin
        state_d    = S_T1;
        wait_cnt_d = '0;
      end
      // A ready on the cycle the limit is reached still completes the fetch.
      S_T1: begin
        if (mem_ready_i) begin
          state_d = S_T2;
        end else if (wait_cnt_q >= WAIT_LAST) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (is_alu || is_md)  state_d = S_T4;
        else if (op == OP_NOP)  state_d = S_NEXT;
        else if (op == OP_HALT) state_d = S_HALT;
        else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_T4: state_d = S_T5;
      S_T5: state_d = is_md ? S_T6 : S_NEXT;
      S_T6: state_d = S_NEXT;
      S_HALT: begin
        if (start_i) begin
          state_d   = S_T0;
          illegal_d = 1'b0;
          bus_err_d = 1'b0;
        end
      end
`ifdef SINGLE_STEP_EN
      S_STEP: if (step_rise) state_d = S_T0;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pcout_o      = 1'b0;
    zhighout_o   = 1'b0;
    zlowout_o    = 1'b0;
    mdrout_o     = 1'b0;
    marin_o      = 1'b0;
    pcin_o       = 1'b0;
    mdrin_o      = 1'b0;
    irin_o       = 1'b0;
    yin_o        = 1'b0;
    zin_o        = 1'b0;
    hiin_o       = 1'b0;
    loin_o       = 1'b0;
    incpc_o      = 1'b0;
    read_o       = 1'b0;
    rout_o       = '0;
    rin_o        = '0;
    alu_op_o     = 5'b0;
    instr_done_o = 1'b0;
    run_o        = (state_q != S_IDLE) && (state_q != S_HALT);
    illegal_o    = illegal_q;
    bus_err_o    = bus_err_q;
    case (state_q)
      S_T0: begin
        pcout_o = 1'b1;
        marin_o = 1'b1;
        incpc_o = 1'b1;
        zin_o   = 1'b1;
      end
      S_T1: begin
        zlowout_o = 1'b1;
        pcin_o    = 1'b1;
        read_o    = 1'b1;
        mdrin_o   = 1'b1;
      end
      S_T2: begin
        mdrout_o = 1'b1;
        irin_o   = 1'b1;
      end
      S_T3: begin
        if (is_alu) begin
          rout_o = reg_sel(rb);
          yin_o  = 1'b1;
        end else if (is_md) begin
          rout_o = reg_sel(ra);
          yin_o  = 1'b1;
        end else if ((op == OP_NOP) || (op == OP_HALT)) begin
          instr_done_o = 1'b1;
        end
      end
      S_T4: begin
        rout_o   = is_md ? reg_sel(rb) : reg_sel(rc);
        zin_o    = 1'b1;
        alu_op_o = op;
      end
      S_T5: begin
        zlowout_o = 1'b1;
        if (is_md) begin
          loin_o = 1'b1;
        end else begin
          rin_o        = reg_sel(ra);
          instr_done_o = 1'b1;
        end
      end
      S_T6: begin
        zhighout_o   = 1'b1;
        hiin_o       = 1'b1;
        instr_done_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: an instruction-level schedule model predicts every output cycle.
module tb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        clear_n, start, mem_ready;
  logic [31:0] ir;
  logic        pcout, zhighout, zlowout, mdrout, marin, pcin, mdrin, irin;
  logic        yin, zin, hiin, loin, incpc, read, run, instr_done, illegal, bus_err;
  logic [15:0] rout, rin;
  logic [4:0]  alu_op;

  always #5 clk = ~clk;

  ctrl_sequencer #(.MEM_WAIT_MAX(15), .NUM_REGS(16)) dut (
    .clk_i(clk), .clear_ni(clear_n), .start_i(start), .mem_ready_i(mem_ready), .ir_i(ir),
    .pcout_o(pcout), .zhighout_o(zhighout), .zlowout_o(zlowout), .mdrout_o(mdrout),
    .marin_o(marin), .pcin_o(pcin), .mdrin_o(mdrin), .irin_o(irin), .yin_o(yin),
    .zin_o(zin), .hiin_o(hiin), .loin_o(loin), .incpc_o(incpc), .read_o(read),
    .rout_o(rout), .rin_o(rin), .alu_op_o(alu_op), .run_o(run),
    .instr_done_o(instr_done), .illegal_o(illegal), .bus_err_o(bus_err)
  );

  typedef struct packed {
    logic pcout, zhighout, zlowout, mdrout, marin, pcin, mdrin, irin;
    logic yin, zin, hiin, loin, incpc, read;
    logic [15:0] rout, rin;
    logic [4:0]  alu_op;
    logic run, instr_done, illegal, bus_err;
  } out_t;

  typedef struct {
    logic        start, mr, clr_n;
    logic [31:0] ir;
    out_t        exp;
    logic        chk_alu, pin_en;
    logic [15:0] pin_rout, pin_rin;
    string       name;
  } rec_t;

  rec_t q[$];
  bit   m_ill, m_berr;
  int   checks = 0;
  int   passes = 0;

  function automatic out_t quiet(bit running);
    out_t o = '0;
    o.run     = running;
    o.illegal = m_ill;
    o.bus_err = m_berr;
    return o;
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] idx);
    logic [15:0] v = 16'h0001;
    return v << idx;
  endfunction

  task automatic push(input logic st, input logic mr, input logic cn, input logic [31:0] i,
                      input out_t e, input logic ca, input string nm);
    rec_t r;
    r.start = st; r.mr = mr; r.clr_n = cn; r.ir = i; r.exp = e; r.chk_alu = ca;
    r.pin_en = 1'b0; r.pin_rout = '0; r.pin_rin = '0; r.name = nm;
    q.push_back(r);
  endtask

  task automatic pin_at(input int idx, input logic [15:0] ro, input logic [15:0] ri);
    rec_t r = q[idx];
    r.pin_en = 1'b1; r.pin_rout = ro; r.pin_rin = ri;
    q[idx] = r;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) push(1'b0, 1'b0, 1'b1, 32'h0, quiet(1'b0), 1'b0, "stopped");
  endtask

  task automatic reset_cycle(input int n);
    m_ill = 1'b0; m_berr = 1'b0;
    for (int k = 0; k < n; k++) push(1'b0, 1'b0, 1'b0, 32'h0, '0, 1'b0, "reset");
  endtask

  task automatic kick();
    push(1'b1, 1'b0, 1'b1, 32'h0, quiet(1'b0), 1'b0, "start");
    m_ill = 1'b0; m_berr = 1'b0;
  endtask

  // One full instruction from its T0: waits = not-ready T1 cycles before data arrives.
  task automatic exec(input logic [31:0] i, input int waits, input bit timeout, input bit clr_t4);
    out_t o;
    logic [4:0] op = i[31:27];
    logic [3:0] ra = i[26:23], rb = i[22:19], rc = i[18:15];
    bit alu = (op <= 5'd11);
    bit md  = (op == 5'd12) || (op == 5'd13);
    o = quiet(1'b1); o.pcout = 1; o.marin = 1; o.incpc = 1; o.zin = 1;
    push(1'b0, 1'b1, 1'b1, i, o, 1'b0, "T0");
    o = quiet(1'b1); o.zlowout = 1; o.pcin = 1; o.read = 1; o.mdrin = 1;
    if (timeout) begin
      for (int k = 0; k < 15; k++) push(1'b0, 1'b0, 1'b1, i, o, 1'b0, "T1_timeout");
      m_berr = 1'b1;
      return;
    end
    for (int k = 0; k <= waits; k++) push(1'b0, k == waits, 1'b1, i, o, 1'b0, "T1");
    o = quiet(1'b1); o.mdrout = 1; o.irin = 1;
    push(1'b1, 1'b0, 1'b1, i, o, 1'b0, "T2");
    o = quiet(1'b1);
    if (alu || md) begin
      o.rout = alu ? oh(rb) : oh(ra); o.yin = 1;
      push(1'b1, 1'b0, 1'b1, i, o, 1'b0, "T3");
      if (clr_t4) begin
        m_ill = 1'b0; m_berr = 1'b0;
        push(1'b0, 1'b0, 1'b0, i, '0, 1'b0, "T4_clear");
        return;
      end
      o = quiet(1'b1); o.rout = alu ? oh(rc) : oh(rb); o.zin = 1; o.alu_op = op;
      push(1'b0, 1'b0, 1'b1, i, o, 1'b1, "T4");
      o = quiet(1'b1); o.zlowout = 1;
      if (alu) begin
        o.rin = oh(ra); o.instr_done = 1;
        push(1'b0, 1'b0, 1'b1, i, o, 1'b0, "T5");
      end else begin
        o.loin = 1;
        push(1'b0, 1'b0, 1'b1, i, o, 1'b0, "T5");
        o = quiet(1'b1); o.zhighout = 1; o.hiin = 1; o.instr_done = 1;
        push(1'b0, 1'b0, 1'b1, i, o, 1'b0, "T6");
      end
    end else if (op == 5'd26 || op == 5'd27) begin
      o.instr_done = 1;
      push(1'b0, 1'b0, 1'b1, i, o, 1'b0, "T3_nop_halt");
    end else begin
      push(1'b0, 1'b0, 1'b1, i, o, 1'b0, "T3_illegal");
      m_ill = 1'b1;
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] a,
                                     input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction

  initial begin
    int b;
    out_t act, e;
    clear_n = 1'b0; start = 1'b0; mem_ready = 1'b0; ir = 32'h0;

    reset_cycle(2);
    idle(2);
    kick();
    b = q.size();
    exec(32'h1A920000, 0, 0, 0);                       // ROR ra=5 rb=2 rc=4
    pin_at(b + 3, 16'h0004, 16'h0000);
    pin_at(b + 4, 16'h0010, 16'h0000);
    pin_at(b + 5, 16'h0000, 16'h0020);
    exec(mk(5'd0, 4'd1, 4'd2, 4'd3), 3, 0, 0);          // ADD with 3 wait cycles
    b = q.size();
    exec(mk(5'd12, 4'd3, 4'd7, 4'd0), 0, 0, 0);         // MUL ra=3 rb=7
    pin_at(b + 3, 16'h0008, 16'h0000);
    pin_at(b + 4, 16'h0080, 16'h0000);
    exec(mk(5'd26, 4'd0, 4'd0, 4'd0), 0, 0, 0);         // NOP
    exec(mk(5'd13, 4'd9, 4'd15, 4'd1), 1, 0, 0);        // DIV
    exec(mk(5'd27, 4'd0, 4'd0, 4'd0), 0, 0, 0);         // HALT
    idle(3);
    kick();
    exec(mk(5'd11, 4'd15, 4'd0, 4'd14), 14, 0, 0);      // last ALU op, ready on final allowed cycle
    exec(mk(5'd31, 4'd2, 4'd2, 4'd2), 0, 0, 0);         // illegal
    idle(2);
    kick();
    exec(mk(5'd0, 4'd1, 4'd1, 4'd1), 0, 1, 0);          // fetch timeout
    idle(2);
    kick();
    exec(mk(5'd14, 4'd4, 4'd4, 4'd4), 0, 0, 0);         // first undefined op above DIV
    idle(1);
    kick();
    exec(mk(5'd12, 4'd2, 4'd6, 4'd0), 0, 0, 1);         // clear during T4
    idle(3);

    repeat (2) @(posedge clk);
    for (int n = 0; n < q.size(); n++) begin
      @(posedge clk);
      #1;
      clear_n = q[n].clr_n; start = q[n].start; mem_ready = q[n].mr; ir = q[n].ir;
      @(negedge clk);
      act = {pcout, zhighout, zlowout, mdrout, marin, pcin, mdrin, irin, yin, zin, hiin,
             loin, incpc, read, rout, rin, alu_op, run, instr_done, illegal, bus_err};
      e = q[n].exp;
      if (!q[n].chk_alu) begin
        act.alu_op = '0;
        e.alu_op   = '0;
      end
      checks++;
      if (act === e) passes++;
      else $display("FAIL %s cycle %0d: got %h want %h", q[n].name, n, act, e);
      if (q[n].pin_en) begin
        checks++;
        if (rout === q[n].pin_rout && rin === q[n].pin_rin) passes++;
        else $display("FAIL pin_%s cycle %0d: rout/rin got %h/%h want %h/%h",
                      q[n].name, n, rout, rin, q[n].pin_rout, q[n].pin_rin);
      end
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Hardwired control unit for the single-bus Datapath. It generates every register-transfer strobe for the fetch cycle (T0–T2) and the execute cycles (T3–T6).
- Replaces hand-driven control sequences in benches. Sits between memory-ready handshake, IR contents and Datapath control inputs.
- Handles three-register ALU ops, MUL/DIV, NOP, HALT, illegal opcodes and a bounded memory-wait timeout.

Parameters:
- MEM_WAIT_MAX, 15, max Clock cycles T1 waits for mem_ready before bus error (1..255)
- NUM_REGS, 16, general registers; width of Rin/Rout one-hot buses

Ports:
- Clock  in  1  system clock, rising edge
- Clear  in  1  asynchronous reset, active-low
- start  in  1  begin/resume execution from IDLE or HALT
- mem_ready  in  1  memory read data valid on Mdatain this cycle
- IR  in  32  instruction register contents from Datapath
- PCout, Zhighout, Zlowout, MDRout  out  1 each  bus drive strobes
- MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1 each  register load strobes
- IncPC, Read  out  1 each  ALU PC-increment, memory read select
- Rout  out  NUM_REGS  one-hot general-register bus drive
- Rin  out  NUM_REGS  one-hot general-register load
- alu_op  out  5  ALU operation code, equal to IR[31:27]; valid only while Zin=1 in T4
- run  out  1  high while sequencing (T0–T6)
- instr_done  out  1  one-cycle pulse in final execute state
- illegal  out  1  sticky; set on undefined opcode
- bus_err  out  1  sticky; set on mem_ready timeout

Behaviour:
- Moore FSM. Outputs are decoded from the registered state plus IR fields only. Each state lasts one Clock, except T1 under wait.
- Clear low forces IDLE asynchronously, from any state including mid-instruction. All outputs, wait counter, illegal and bus_err go to 0.
- IR fields: op=IR[31:27], ra=IR[26:23], rb=IR[22:19], rc=IR[18:15].
- IDLE: all outputs 0. start=1 -> T0.
- T0: PCout, MARin, IncPC, Zin. -> T1.
- T1: Zlowout, PCin, Read, MDRin. Wait counter clears on entry.
  - mem_ready=1 -> T2.
  - Otherwise stay in T1 and increment the counter. Repeated PCin is idempotent because Z is not reloaded.
  - If the counter reaches MEM_WAIT_MAX with mem_ready still 0 -> HALT and set bus_err.
  - mem_ready=1 on the same cycle the limit is reached wins -> T2.
- T2: MDRout, IRin. -> T3.
- T3: decode op.
  - op 00000–01011 (three-register ALU; 00011=ROR): Rout[rb], Yin. -> T4.
  - op 01100 MUL / 01101 DIV: Rout[ra], Yin. -> T4.
  - op 11010 NOP: instr_done. -> T0.
  - op 11011 HALT: instr_done. -> HALT.
  - Any other op: set illegal. -> HALT.
- T4: Rout[rc] (ALU class) or Rout[rb] (MUL/DIV); Zin; alu_op=op. -> T5.
- T5:
  - ALU class: Zlowout, Rin[ra], instr_done. -> T0.
  - MUL/DIV: Zlowout, LOin. -> T6.
- T6: Zhighout, HIin, instr_done. -> T0.
- HALT: run=0, all strobes 0. start=1 -> T0 and clears illegal and bus_err. start has no effect in T0–T6.
- Rin and Rout are never more than one-hot. At most one bus-drive strobe is high per cycle across PCout, Zhighout, Zlowout, MDRout and Rout.

Optional Feature:
- SINGLE_STEP_EN defined:
  - Adds input step (1 bit) and state STEP_WAIT.
  - Every transition that would return to T0 after instr_done goes to STEP_WAIT instead. run stays 1 and all strobes are 0 there.
  - A step rising edge (registered, edge-detected) -> T0. Clear low still forces IDLE.
- SINGLE_STEP_EN undefined: no step port, no STEP_WAIT; execution is free-running.

Test Plan:
- ROR: IR=32'h1A920000 (op 00011, ra=5, rb=2, rc=4), mem_ready=1, start pulse -> states T0,T1,T2,T3,T4,T5 on consecutive cycles; Rout=16'h0004 with Yin in T3; Rout=16'h0010, Zin, alu_op=5'b00011 in T4; Rin=16'h0020, Zlowout, instr_done in T5; T0 follows.
- Memory wait: mem_ready low for 3 cycles in T1 -> Read, MDRin held 4 cycles; IRin asserts exactly 1 cycle later; bus_err stays 0.
- Timeout: mem_ready held 0, MEM_WAIT_MAX=15 -> HALT after 15 T1 cycles; bus_err=1; run=0. Next start -> bus_err=0, T0.
- MUL: IR op=01100, ra=3, rb=7 -> Rout=16'h0008 in T3, Rout=16'h0080 in T4, LOin in T5, HIin in T6, instr_done only in T6.
- HALT/illegal: op=11011 -> HALT, illegal=0. op=11111 -> HALT, illegal=1. No Rin asserted in either case.
- Reset mid-op: Clear low during T4 -> same-cycle (asynchronous) return of all outputs to 0 and IDLE. Clear high with start=0 -> stays IDLE.
